// File: rtl/addr_gen_strided_if.sv
// Handshake and configuration bundle between a sequencing FSM / memory port
// and the strided address generator.
interface addr_gen_strided_if #(
  parameter int ADDR_WIDTH   = 7,
  parameter int LEN_WIDTH    = 8,
  parameter int STRIDE_WIDTH = 4
);
  logic                    start_i;
  logic                    clear_i;
  logic                    mode_i;
  logic [ADDR_WIDTH-1:0]   base_i;
  logic [LEN_WIDTH-1:0]    len_i;
  logic [STRIDE_WIDTH-1:0] stride_i;
  logic                    ready_i;
  logic [ADDR_WIDTH-1:0]   addr_o;
  logic                    valid_o;
  logic                    last_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    output start_i, clear_i, mode_i, base_i, len_i, stride_i, ready_i,
    input  addr_o, valid_o, last_o, busy_o, done_o
  );

  modport slave (
    input  start_i, clear_i, mode_i, base_i, len_i, stride_i, ready_i,
    output addr_o, valid_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/addr_gen_strided.sv
// Strided burst address generator: base, base+stride, ... for len beats,
// with ready/valid backpressure, one-shot or loop mode and synchronous abort.
//
// state  | meaning
// IDLE   | waiting for start_i; config registers hold last burst
// RUN    | valid_o high, addr_o presented, advancing on each handshake
// DONE   | one-cycle done_o pulse after a one-shot (or empty) burst
module addr_gen_strided #(
  parameter int ADDR_WIDTH   = 7,
  parameter int LEN_WIDTH    = 8,
  parameter int STRIDE_WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  addr_gen_strided_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic                    mode_q, mode_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;

  logic [LEN_WIDTH-1:0]    cnt_inc;
  logic [LEN_WIDTH-1:0]    len_m1;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic                    xfer;

  assign cnt_inc  = cnt_q + LEN_WIDTH'(1);
  assign len_m1   = len_q - LEN_WIDTH'(1);
  assign addr_inc = addr_q + ADDR_WIDTH'(stride_q);
  assign xfer     = (state_q == S_RUN) && bus.ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      stride_q <= '0;
      mode_q   <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      stride_q <= stride_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    stride_d = stride_q;
    mode_d   = mode_q;
    last_d   = last_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        last_d = 1'b0;
        if (bus.start_i && !bus.clear_i) begin
          base_d   = bus.base_i;
          len_d    = bus.len_i;
          stride_d = bus.stride_i;
          mode_d   = bus.mode_i;
          cnt_d    = '0;
          if (bus.len_i != '0) begin
            state_d = S_RUN;
            addr_d  = bus.base_i;
            last_d  = (bus.len_i == LEN_WIDTH'(1));
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        // Abort wins over a concurrent handshake: address is frozen, no done.
        if (bus.clear_i) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end else if (xfer) begin
          if (last_q) begin
            done_d = 1'b1;
            if (mode_q) begin
              addr_d = base_q;
              cnt_d  = '0;
              last_d = (len_q == LEN_WIDTH'(1));
            end else begin
              state_d = S_DONE;
              addr_d  = addr_inc;
              cnt_d   = cnt_inc;
              last_d  = 1'b0;
            end
          end else begin
            addr_d = addr_inc;
            cnt_d  = cnt_inc;
            last_d = (cnt_inc == len_m1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        last_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        last_d  = 1'b0;
      end
    endcase
  end

  assign bus.addr_o  = addr_q;
  assign bus.valid_o = (state_q == S_RUN);
  assign bus.last_o  = last_q;
  assign bus.busy_o  = (state_q != S_IDLE);
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_addr_gen_strided.sv
// Directed self-checking bench for addr_gen_strided; observation vector is
// {valid, last, done, busy, addr}.
module tb_addr_gen_strided;
  localparam int AW = 7;
  localparam int LW = 8;
  localparam int SW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  addr_gen_strided_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)) bus ();

  addr_gen_strided #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [10:0] obs;
  assign obs = {bus.valid_o, bus.last_o, bus.done_o, bus.busy_o, bus.addr_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] pk(input logic v, input logic l, input logic d,
                                     input logic b, input int a);
    logic [6:0] a7;
    a7 = a[6:0];
    return {v, l, d, b, a7};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int base, input int len, input int stride, input logic mode);
    bus.base_i   = base[AW-1:0];
    bus.len_i    = len[LW-1:0];
    bus.stride_i = stride[SW-1:0];
    bus.mode_i   = mode;
    bus.start_i  = 1'b1;
    step();
    bus.start_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.clear_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.base_i  = '0;
    bus.len_i   = '0;
    bus.stride_i = '0;
    bus.ready_i = 1'b1;
    #13;
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL reset: obs=%b required=%b", obs, 11'd0);
    end
    #4 rst_n = 1'b1;
    step();
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL reset_release: obs=%b required=%b", obs, 11'd0);
    end
  endtask

  task automatic test_one_shot();
    logic [10:0] exp [6];
    exp = '{pk(1,0,0,1,10), pk(1,0,0,1,13), pk(1,0,0,1,16), pk(1,1,0,1,19),
            pk(0,0,1,1,22), pk(0,0,0,0,22)};
    bus.ready_i = 1'b1;
    do_start(10, 4, 3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL one_shot[%0d]: obs=%b required=%b", i, obs, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] exp [7];
    logic        rdy [7];
    exp = '{pk(1,0,0,1,0), pk(1,0,0,1,1), pk(1,0,0,1,1), pk(1,0,0,1,1),
            pk(1,1,0,1,2), pk(0,0,1,1,3), pk(0,0,0,0,3)};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus.ready_i = 1'b1;
    do_start(0, 3, 1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bus.ready_i = rdy[i];
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL backpressure[%0d]: obs=%b required=%b", i, obs, exp[i]);
      end
      step();
    end
    bus.ready_i = 1'b1;
  endtask

  task automatic test_wrap();
    logic [10:0] exp [6];
    exp = '{pk(1,0,0,1,126), pk(1,0,0,1,127), pk(1,0,0,1,0), pk(1,1,0,1,1),
            pk(0,0,1,1,2), pk(0,0,0,0,2)};
    bus.ready_i = 1'b1;
    do_start(126, 4, 1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: obs=%b required=%b", i, obs, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_len_zero();
    do_start(40, 0, 1, 1'b0);
    checks++;
    if ({bus.valid_o, bus.done_o, bus.busy_o} !== 3'b011) begin
      errors++;
      $display("FAIL len_zero_t1: v/d/b=%b required=011", {bus.valid_o, bus.done_o, bus.busy_o});
    end
    step();
    checks++;
    if ({bus.valid_o, bus.done_o, bus.busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL len_zero_t2: v/d/b=%b required=000", {bus.valid_o, bus.done_o, bus.busy_o});
    end
  endtask

  task automatic test_loop_clear();
    logic [10:0] exp [6];
    exp = '{pk(1,0,0,1,5), pk(1,1,0,1,7), pk(1,0,1,1,5), pk(1,1,0,1,7),
            pk(1,0,1,1,5), pk(1,1,0,1,7)};
    bus.ready_i = 1'b1;
    do_start(5, 2, 2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.clear_i = 1'b1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL loop[%0d]: obs=%b required=%b", i, obs, exp[i]);
      end
      step();
    end
    bus.clear_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== pk(0,0,0,0,7)) begin
        errors++;
        $display("FAIL loop_clear[%0d]: obs=%b required=%b", i, obs, pk(0,0,0,0,7));
      end
      step();
    end
  endtask

  task automatic test_start_clear();
    bus.clear_i = 1'b1;
    do_start(60, 3, 1, 1'b0);
    bus.clear_i = 1'b0;
    checks++;
    if ({bus.valid_o, bus.done_o, bus.busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL start_clear: v/d/b=%b required=000", {bus.valid_o, bus.done_o, bus.busy_o});
    end
  endtask

  task automatic test_start_busy();
    logic [10:0] exp [5];
    exp = '{pk(1,0,0,1,20), pk(1,0,0,1,21), pk(1,1,0,1,22), pk(0,0,1,1,23), pk(0,0,0,0,23)};
    bus.ready_i = 1'b1;
    do_start(20, 3, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        bus.start_i  = 1'b1;
        bus.base_i   = 7'd50;
        bus.len_i    = 8'd5;
        bus.stride_i = 4'd4;
      end else begin
        bus.start_i = 1'b0;
      end
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL start_busy[%0d]: obs=%b required=%b", i, obs, exp[i]);
      end
      step();
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.ready_i = 1'b1;
    do_start(10, 4, 3, 1'b0);
    step();
    checks++;
    if (obs !== pk(1,0,0,1,13)) begin
      errors++;
      $display("FAIL async_pre: obs=%b required=%b", obs, pk(1,0,0,1,13));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: obs=%b required=%b", obs, 11'd0);
    end
    #2 rst_n = 1'b1;
    test_one_shot();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_one_shot();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_loop_clear();
    test_start_clear();
    test_start_busy();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_gen_strided.md
Name: addr_gen_strided

Overview:
- Parametrised successor to the single-channel address counter: generates a burst of `len_i` addresses `base_i, base_i+stride_i, ...` toward a memory/buffer port.
- Adds over the plain counter: programmable base/length/stride, ready/valid backpressure, one-shot or continuous (loop) mode, `last_o`/`done_o` status, synchronous abort.
- Sits between a control FSM (drives `start_i`/`clear_i`) and an SRAM/FIFO read or write port (drives `ready_i`).

Parameters:
- ADDR_WIDTH, 7, width of generated address; arithmetic is modulo 2^ADDR_WIDTH.
- LEN_WIDTH, 8, width of burst length; must be ≥ ADDR_WIDTH+1 so a full 2^ADDR_WIDTH sweep is expressible.
- STRIDE_WIDTH, 4, width of unsigned stride; zero-extended to ADDR_WIDTH for addition.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  start request; sampled only in IDLE.
- clear_i  input  1  synchronous abort; returns to IDLE from any state.
- mode_i  input  1  0 = one-shot, 1 = loop; latched at start.
- base_i  input  ADDR_WIDTH  first address; latched at start.
- len_i  input  LEN_WIDTH  beats per burst; latched at start.
- stride_i  input  STRIDE_WIDTH  address increment per beat; latched at start.
- ready_i  input  1  downstream accepts the current beat.
- addr_o  output  ADDR_WIDTH  current address, registered.
- valid_o  output  1  `addr_o` is valid, registered.
- last_o  output  1  current beat is the final beat of the burst, registered.
- busy_o  output  1  state != IDLE.
- done_o  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (async, `rst_n`=0): state = IDLE; `addr_o`=0, `valid_o`=0, `last_o`=0, `busy_o`=0, `done_o`=0; latched config and beat counter = 0.
- States:
  - IDLE → RUN on `start_i`=1 && `len_i`!=0 && `clear_i`=0.
  - IDLE → DONE on `start_i`=1 && `len_i`==0 && `clear_i`=0.
  - RUN → DONE after the last beat's handshake in one-shot mode.
  - RUN stays in RUN across the last beat in loop mode.
  - DONE → IDLE unconditionally after 1 cycle.
  - Any state → IDLE on `clear_i`=1.
- Start latency: `start_i` accepted at edge t; from t+1 `valid_o`=1, `addr_o`=`base_i`, beat count = 0, `last_o` = (`len_i`==1).
- `valid_o` = 1 exactly while in RUN.
- Handshake: a beat transfers on a rising edge when `valid_o`=1 && `ready_i`=1.
  - On transfer: `addr_o` ← `addr_o` + stride (mod 2^ADDR_WIDTH); count ← count+1.
  - With `ready_i`=0: `addr_o`, `last_o`, count hold; `valid_o` stays 1; no dropping, no retraction.
- `last_o` = 1 while count == len−1 and in RUN; 0 otherwise.
- Burst end on the last transfer:
  - One-shot: next cycle state = DONE, `valid_o`=0, `last_o`=0, `done_o`=1 for exactly that cycle; then IDLE.
  - Loop: next cycle `addr_o`=base, count=0, `valid_o` stays 1, `done_o`=1 for one cycle; continues until `clear_i`.
- `len_i`=0: no beats issued; `done_o` pulses at t+1; `valid_o` never asserts.
- `stride_i`=0: same address repeated `len` times (legal).
- Address wrap: `base_i`=126, stride 1, `ADDR_WIDTH`=7 gives 126, 127, 0, 1, … ; no flag, no error.
- `start_i` while `busy_o`=1: ignored; latched config unchanged.
- `clear_i` priority: over `start_i` in the same cycle (stay IDLE), over a concurrent handshake (beat counts as transferred downstream, but no `done_o`).
  - Next cycle after `clear_i`: `valid_o`=0, `last_o`=0, `done_o`=0, `addr_o` holds its last value.
- Reset asserted mid-burst: all outputs clear immediately (async), regardless of clock.
- Arithmetic: count is LEN_WIDTH bits; comparisons unsigned; `len_i`=2^ADDR_WIDTH sweeps every address exactly once with stride 1.

Test Plan:
- One-shot, base=10, len=4, stride=3, `ready_i`=1: `addr_o` 10,13,16,19 on 4 consecutive cycles; `last_o` only with 19; `done_o` pulses 1 cycle after, then `busy_o`=0.
- Backpressure, base=0, len=3, stride=1, `ready_i` low on cycles 2–3: `addr_o` holds 1 with `valid_o`=1; total 3 transfers 0,1,2; `done_o` once.
- Wrap, base=126, len=4, stride=1: 126,127,0,1; `done_o` pulse. Also len=0: `done_o` at t+1, `valid_o` never 1.
- Loop mode, base=5, len=2, stride=2: 5,7,5,7,… with `done_o` after each 7; `clear_i` mid-burst → `valid_o`=0 next cycle, state IDLE, no extra `done_o`.
- `start_i` while busy (new base=50): ignored, original sequence completes. `start_i`+`clear_i` same cycle: stays IDLE.
- `rst_n` pulled low asynchronously mid-burst (between edges): `valid_o`, `addr_o`, `busy_o` = 0 immediately; fresh start after release behaves as the first scenario.
